// File: rtl/pipe_ctrl_path_pkg.sv
// Shared definitions for the pipeline control path: opcodes, ALU classes,
// halt constants, the control-word bit layout and the halt sequencer states.
package pipe_ctrl_path_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_CTRL_ADD    = 2'b00;
  localparam logic [1:0] ALU_CTRL_BRANCH = 2'b01;
  localparam logic [1:0] ALU_CTRL_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_CTRL_ITYPE  = 2'b11;

  localparam int HALT_REG_IDX = 17;
  localparam int HALT_VAL     = 10;

  // Control-word layout shared by every stage register; alu_op sits on top.
  localparam int CTL_MEM_READ   = 0;
  localparam int CTL_MEM_TO_REG = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_ALU_SRC    = 3;
  localparam int CTL_REG_WRITE  = 4;
  localparam int CTL_ALU_OP_LSB = 5;

  typedef enum logic [1:0] {
    HS_RUN       = 2'd0,
    HS_DRAIN_MEM = 2'd1,
    HS_DRAIN_WB  = 2'd2,
    HS_HALTED    = 2'd3
  } halt_state_e;

endpackage

// File: rtl/pipe_ctrl_path_hazard_detect.sv
// Combinational hazard detection for the instruction sitting in ID:
// load-use against EX, and the ecall's x17 operand against EX and MEM.
module pipe_ctrl_path_hazard_detect
  import pipe_ctrl_path_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int HALT_REG   = HALT_REG_IDX
) (
  input  logic                  id_valid_i,
  input  logic                  id_is_ecall_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_reg_write_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  output logic                  load_use_o,
  output logic                  ecall_hz_o
);

  localparam logic [REG_ADDR_W-1:0] HALT_RD = REG_ADDR_W'(HALT_REG);

  logic rs1_hit;
  logic rs2_hit;
  logic ex_writes_halt;
  logic mem_writes_halt;

  // x0 is never a real producer, so rd==0 is excluded from every match.
  always_comb begin
    rs1_hit         = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit         = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    load_use_o      = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    ex_writes_halt  = ex_valid_i && ex_reg_write_i && (ex_rd_i != '0) && (ex_rd_i == HALT_RD);
    mem_writes_halt = mem_valid_i && mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == HALT_RD);
    ecall_hz_o      = id_valid_i && id_is_ecall_i && (ex_writes_halt || mem_writes_halt);
  end

endmodule

// File: rtl/pipe_ctrl_path.sv
// Pipeline control path: carries the decoded control word through ID/EX,
// EX/MEM and MEM/WB, inserts bubbles on hazards and sequences halt on a
// qualifying ecall.
//
// state        | meaning
// HS_RUN       | normal operation, no halt seen
// HS_DRAIN_MEM | halting ecall is in MEM, front end frozen
// HS_DRAIN_WB  | halting ecall is in WB, front end frozen
// HS_HALTED    | ecall retired, is_halted held until reset
module pipe_ctrl_path
  import pipe_ctrl_path_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 2,
  parameter int HALT_REG   = HALT_REG_IDX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  id_is_ecall,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_halt_cond,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  is_halted
);

  localparam int CTL_W = CTL_ALU_OP_LSB + ALU_OP_W;

  typedef struct packed {
    logic                  valid;
    logic [CTL_W-1:0]      ctl;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_ecall;
  } stage_t;

  stage_t      ex_q, ex_d, mem_q, wb_q;
  stage_t      ex_v, mem_v, wb_v;
  halt_state_e hs_q, hs_d;
  logic        load_use, ecall_hz, stall;
  logic        halt_fire, halt_pending;

  pipe_ctrl_path_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W),
    .HALT_REG   (HALT_REG)
  ) u_hazard (
    .id_valid_i      (id_valid),
    .id_is_ecall_i   (id_is_ecall),
    .id_uses_rs1_i   (id_uses_rs1),
    .id_uses_rs2_i   (id_uses_rs2),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .ex_valid_i      (ex_q.valid),
    .ex_mem_read_i   (ex_q.ctl[CTL_MEM_READ]),
    .ex_reg_write_i  (ex_q.ctl[CTL_REG_WRITE]),
    .ex_rd_i         (ex_q.rd),
    .mem_valid_i     (mem_q.valid),
    .mem_reg_write_i (mem_q.ctl[CTL_REG_WRITE]),
    .mem_rd_i        (mem_q.rd),
    .load_use_o      (load_use),
    .ecall_hz_o      (ecall_hz)
  );

  // Halt sequencer next state; halt_fire marks the edge the halting ecall leaves EX.
  always_comb begin
    hs_d      = hs_q;
    halt_fire = 1'b0;
    unique case (hs_q)
      HS_RUN: begin
        if (ex_q.valid && ex_q.is_ecall && ex_halt_cond) begin
          halt_fire = 1'b1;
          hs_d      = HS_DRAIN_MEM;
        end
      end
      HS_DRAIN_MEM: hs_d = HS_DRAIN_WB;
      HS_DRAIN_WB:  hs_d = HS_HALTED;
      HS_HALTED:    hs_d = HS_HALTED;
      default:      hs_d = HS_RUN;
    endcase
  end

  // Front-end enables and ID/EX load; the instruction in ID is also dropped on
  // the halt_fire edge so nothing younger than the ecall ever reaches EX.
  always_comb begin
    halt_pending = (hs_q != HS_RUN);
    stall        = id_valid && (load_use || ecall_hz);
    pc_write     = !halt_pending && !stall;
    if_id_write  = !halt_pending && !stall;
    ex_d         = '0;
    if (!(stall || halt_pending || halt_fire)) begin
      ex_d.valid                                 = id_valid;
      ex_d.ctl[CTL_MEM_READ]                     = id_mem_read;
      ex_d.ctl[CTL_MEM_TO_REG]                   = id_mem_to_reg;
      ex_d.ctl[CTL_MEM_WRITE]                    = id_mem_write;
      ex_d.ctl[CTL_ALU_SRC]                      = id_alu_src;
      ex_d.ctl[CTL_REG_WRITE]                    = id_reg_write;
      ex_d.ctl[CTL_ALU_OP_LSB +: ALU_OP_W]       = id_alu_op;
      ex_d.rd                                    = id_rd;
      ex_d.is_ecall                              = id_is_ecall;
    end
  end

  // Stage registers and halt state; EX/MEM and MEM/WB always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      hs_q  <= HS_RUN;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      hs_q  <= hs_d;
    end
  end

  // Invalid stages present an all-zero control word.
  always_comb begin
    ex_v  = ex_q.valid  ? ex_q  : '0;
    mem_v = mem_q.valid ? mem_q : '0;
    wb_v  = wb_q.valid  ? wb_q  : '0;
  end

  assign ex_mem_read    = ex_v.ctl[CTL_MEM_READ];
  assign ex_mem_to_reg  = ex_v.ctl[CTL_MEM_TO_REG];
  assign ex_mem_write   = ex_v.ctl[CTL_MEM_WRITE];
  assign ex_alu_src     = ex_v.ctl[CTL_ALU_SRC];
  assign ex_reg_write   = ex_v.ctl[CTL_REG_WRITE];
  assign ex_alu_op      = ex_v.ctl[CTL_ALU_OP_LSB +: ALU_OP_W];
  assign ex_rd          = ex_v.rd;
  assign mem_mem_read   = mem_v.ctl[CTL_MEM_READ];
  assign mem_mem_write  = mem_v.ctl[CTL_MEM_WRITE];
  assign mem_mem_to_reg = mem_v.ctl[CTL_MEM_TO_REG];
  assign mem_reg_write  = mem_v.ctl[CTL_REG_WRITE];
  assign mem_rd         = mem_v.rd;
  assign wb_mem_to_reg  = wb_v.ctl[CTL_MEM_TO_REG];
  assign wb_reg_write   = wb_v.ctl[CTL_REG_WRITE];
  assign wb_rd          = wb_v.rd;
  assign is_halted      = (hs_q == HS_HALTED);

  // Fields carried for stage-register uniformity but not consumed downstream.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{ex_v.valid, ex_v.is_ecall,
                               mem_v.valid, mem_v.is_ecall, mem_v.ctl[CTL_ALU_SRC],
                               mem_v.ctl[CTL_ALU_OP_LSB +: ALU_OP_W],
                               wb_v.valid, wb_v.is_ecall, wb_v.ctl[CTL_MEM_READ],
                               wb_v.ctl[CTL_MEM_WRITE], wb_v.ctl[CTL_ALU_SRC],
                               wb_v.ctl[CTL_ALU_OP_LSB +: ALU_OP_W]};

endmodule
